mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single memory port between the instruction fetch unit (IFU, read-only)
//  and the load/store unit (LSU, read/write). One transaction is outstanding at a time.
//  Round-robin arbitration on conflict; requests are latched, so there is no
//  combinational path from a requester to the memory port. A per-transaction
//  watchdog flags a memory that never responds.
//  Sits between IFU/LSU and the memory model/bus bridge in the multi-cycle core.
// PARAMETERS
//  ADDR_W   32   address width
//  DATA_W   32   data width; the write mask is DATA_W/8 bits
//  TIMEOUT  255  max WAIT cycles before abort; 0 disables the watchdog
// PORTS
//  clk            in   1        clock, rising edge
//  rst            in   1        synchronous, active-high reset
//  ifu_req_valid  in   1        IFU read request
//  ifu_req_ready  out  1        IFU request accepted this cycle
//  ifu_addr       in   ADDR_W   IFU read address
//  ifu_rsp_valid  out  1        one-cycle pulse: ifu_rsp_data is valid
//  ifu_rsp_data   out  DATA_W   fetched word
//  lsu_req_valid  in   1        LSU request
//  lsu_req_ready  out  1        LSU request accepted this cycle
//  lsu_addr       in   ADDR_W   LSU address
//  lsu_wen        in   1        1 = write, 0 = read
//  lsu_wdata      in   DATA_W   write data
//  lsu_wmask      in   DATA_W/8 byte strobes (write only)
//  lsu_rsp_valid  out  1        one-cycle pulse: read data valid / write done
//  lsu_rsp_data   out  DATA_W   read data (0 for writes)
//  mem_req_valid  out  1        request to memory
//  mem_req_ready  in   1        memory accepts the request
//  mem_addr/mem_wen/mem_wdata/mem_wmask  out  as LSU  latched request fields
//  mem_rsp_valid  in   1        memory response; earliest 1 cycle after accept
//  mem_rsp_data   in   DATA_W   response data
//  owner          out  1        0 = IFU, 1 = LSU (the current or last granted requester)
//  timeout_err    out  1        sticky: the watchdog fired
// BEHAVIOUR
//  Reset: state=IDLE, last_grant=IFU, owner=0, timeout_err=0, counter=0.
//   All valid/ready outputs are 0; mem_* request fields are 0.
//  FSM states: IDLE, REQ, WAIT.
//  IDLE: grant goes to the only valid requester.
//   If both are valid, grant the one not equal to last_grant. LSU therefore wins
//   the first conflict after reset.
//   The winner's *_req_ready=1 in the same cycle (combinational in IDLE only).
//   The loser's ready is 0.
//   On grant, latch the request fields into mem_* (IFU: wen=0, wmask=0, wdata=0).
//   Set owner and last_grant to the winner, then go to REQ.
//  REQ: mem_req_valid=1 and the mem_* fields are held stable until mem_req_ready=1.
//   On that handshake, go to WAIT and clear the counter.
//  WAIT: mem_req_valid=0 and the counter increments each cycle.
//   On mem_rsp_valid, route to the owner: owner's *_rsp_valid=1 for exactly that
//   cycle, *_rsp_data=mem_rsp_data. Then go to IDLE.
//   For LSU writes, lsu_rsp_data=0.
//   If TIMEOUT!=0 and the counter reaches TIMEOUT with no response: owner
//   rsp_valid=1 with data=0, timeout_err<=1, go to IDLE.
//  mem_rsp_valid outside WAIT is ignored.
//  Non-owner rsp_valid is always 0. Both rsp_valid are never 1 together.
//  Minimum latency, from accept cycle N: mem_req_valid in N+1, response at
//   earliest N+2, next grant at earliest N+3.
//  Counter width is $clog2(TIMEOUT+1). It saturates and never wraps.
//  Requesters hold valid and fields stable until ready. Dropping valid before ready is legal.
//  Reset mid-transaction: aborts immediately, with no rsp pulse to the owner.
//   Later mem_rsp_valid is ignored (state IDLE).
// TESTING
//  1. IFU only, ifu_addr=0x8000_0000, mem_req_ready=1, rsp 2 cycles later data=0x0010_0093
//     -> ifu_rsp_valid one cycle, data 0x0010_0093; lsu_rsp_valid stays 0.
//  2. Both valid the first cycle after reset (IFU 0x8000_0004, LSU 0x8000_1000)
//     -> lsu_req_ready=1, ifu_req_ready=0; mem_addr order 0x8000_1000, then 0x8000_0004.
//  3. Both valid continuously for 4 transactions -> grants L, I, L, I; owner toggles.
//  4. LSU write 0x1234_ABCD, wmask 4'b0011, mem_req_ready low for 3 cycles
//     -> mem_* stable for 4 cycles; lsu_rsp_valid with data 0 after the response.
//  5. TIMEOUT=8, memory never responds -> 8 cycles after the handshake the owner rsp_valid=1,
//     data 0; timeout_err=1 and stays 1; the next request is served normally.
//  6. rst asserted in WAIT, mem_rsp_valid 2 cycles later -> no rsp_valid pulses,
//     mem_req_valid=0, state IDLE.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester memory port arbiter: IFU (read-only) and LSU (read/write) share one
// memory port, one transaction in flight, round-robin on conflict, with a response watchdog.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_rsp_valid,
    output logic [DATA_W-1:0]   ifu_rsp_data,
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic                lsu_wen,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_rsp_valid,
    output logic [DATA_W-1:0]   lsu_rsp_data,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_rsp_valid,
    input  logic [DATA_W-1:0]   mem_rsp_data,
    output logic                owner,
    output logic                timeout_err,
    output logic [1:0]          dbg_state
);

    localparam int             CNT_W       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit             WD_EN       = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               grant_ifu;
    logic               grant_lsu;
    logic               timeout_hit;
    logic               rsp_fire;
    logic [DATA_W-1:0]  rsp_word;

    // owner doubles as the round-robin history: it always holds the last winner.
    always_comb begin
        grant_ifu = 1'b0;
        grant_lsu = 1'b0;
        if (!rst && state == IDLE) begin
            if (ifu_req_valid && lsu_req_valid) begin
                grant_lsu = ~owner;
                grant_ifu = owner;
            end else begin
                grant_ifu = ifu_req_valid;
                grant_lsu = lsu_req_valid;
            end
        end
    end

    assign ifu_req_ready = grant_ifu;
    assign lsu_req_ready = grant_lsu;
    assign dbg_state     = state;

    always_comb begin
        timeout_hit = WD_EN && (cnt == TIMEOUT_CNT);
        rsp_fire    = !rst && (state == WAIT) && (mem_rsp_valid || timeout_hit);
        // A watchdog abort and any write completion both return zero data.
        rsp_word    = (mem_rsp_valid && !mem_wen) ? mem_rsp_data : '0;
    end

    assign ifu_rsp_valid = rsp_fire && !owner;
    assign lsu_rsp_valid = rsp_fire && owner;
    assign ifu_rsp_data  = ifu_rsp_valid ? rsp_word : '0;
    assign lsu_rsp_data  = lsu_rsp_valid ? rsp_word : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            owner         <= 1'b0;
            timeout_err   <= 1'b0;
            mem_req_valid <= 1'b0;
            mem_addr      <= '0;
            mem_wen       <= 1'b0;
            mem_wdata     <= '0;
            mem_wmask     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_lsu) begin
                        mem_addr      <= lsu_addr;
                        mem_wen       <= lsu_wen;
                        mem_wdata     <= lsu_wdata;
                        mem_wmask     <= lsu_wmask;
                        owner         <= 1'b1;
                        mem_req_valid <= 1'b1;
                        state         <= REQ;
                    end else if (grant_ifu) begin
                        mem_addr      <= ifu_addr;
                        mem_wen       <= 1'b0;
                        mem_wdata     <= '0;
                        mem_wmask     <= '0;
                        owner         <= 1'b0;
                        mem_req_valid <= 1'b1;
                        state         <= REQ;
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        cnt           <= '0;
                        state         <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt != {CNT_W{1'b1}}) begin
                        cnt <= cnt + 1'b1;
                    end
                    if (mem_rsp_valid || timeout_hit) begin
                        if (!mem_rsp_valid) begin
                            timeout_err <= 1'b1;
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a memory responder model, requester drivers and a
// queue-based scoreboard checking memory requests and routed responses.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = DW / 8;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ifu_req_valid = 1'b0;
    logic          ifu_req_ready;
    logic [AW-1:0] ifu_addr = '0;
    logic          ifu_rsp_valid;
    logic [DW-1:0] ifu_rsp_data;
    logic          lsu_req_valid = 1'b0;
    logic          lsu_req_ready;
    logic [AW-1:0] lsu_addr = '0;
    logic          lsu_wen = 1'b0;
    logic [DW-1:0] lsu_wdata = '0;
    logic [MW-1:0] lsu_wmask = '0;
    logic          lsu_rsp_valid;
    logic [DW-1:0] lsu_rsp_data;
    logic          mem_req_valid;
    logic          mem_req_ready = 1'b0;
    logic [AW-1:0] mem_addr;
    logic          mem_wen;
    logic [DW-1:0] mem_wdata;
    logic [MW-1:0] mem_wmask;
    logic          mem_rsp_valid = 1'b0;
    logic [DW-1:0] mem_rsp_data = '0;
    logic          owner;
    logic          timeout_err;
    logic [1:0]    dbg_state;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_data(ifu_rsp_data),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_data(lsu_rsp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .owner(owner), .timeout_err(timeout_err), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #50000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 50000");
        $fatal(1);
    end

    // scoreboard state
    logic [32:0] exp_q[$];       // {is_lsu, data}
    logic [68:0] exp_mem_q[$];   // {addr, wen, wdata, wmask}
    logic [31:0] rsp_q[$];       // data the memory model returns
    int n_checks = 0;
    int n_pass   = 0;

    // memory model controls
    int mem_stall  = 0;
    int rsp_gap    = 0;
    bit mem_silent = 1'b0;
    int hs_cyc     = 0;
    int last_req_len = 0;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    task automatic bound_fail(input string name);
        n_checks++;
        $display("FAIL %s: wait bound expired, got no event required one", name);
    endtask

    // memory responder
    initial begin
        forever begin
            @(posedge clk); #1;
            mem_rsp_valid = 1'b0;
            mem_rsp_data  = '0;
            if (mem_req_valid === 1'b1 && !rst) begin
                repeat (mem_stall) begin @(posedge clk); #1; end
                mem_req_ready = 1'b1;
                hs_cyc = cyc;
                @(posedge clk); #1;
                mem_req_ready = 1'b0;
                if (!mem_silent) begin
                    repeat (rsp_gap) begin @(posedge clk); #1; end
                    mem_rsp_valid = 1'b1;
                    mem_rsp_data  = (rsp_q.size() > 0) ? rsp_q.pop_front() : 32'h0;
                end
            end
        end
    end

    // monitor
    initial begin
        logic [68:0] prev_fields;
        logic [68:0] cur;
        logic [32:0] e;
        bit prev_pending;
        int req_len;
        prev_pending = 1'b0;
        prev_fields  = '0;
        req_len      = 0;
        forever begin
            @(negedge clk);
            if (ifu_rsp_valid === 1'b1 && lsu_rsp_valid === 1'b1) begin
                n_checks++;
                $display("FAIL rsp_exclusive: got both rsp_valid=1 required at most one");
            end else if (ifu_rsp_valid === 1'b1 || lsu_rsp_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL rsp_unexpected: got rsp ifu=%0b lsu=%0b required none", ifu_rsp_valid, lsu_rsp_valid);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_port_data", {lsu_rsp_valid, (lsu_rsp_valid ? lsu_rsp_data : ifu_rsp_data)}, e);
                    check("rsp_owner", owner, e[32]);
                end
            end
            if (mem_req_valid === 1'b1) begin
                cur = {mem_addr, mem_wen, mem_wdata, mem_wmask};
                if (prev_pending) check("mem_fields_stable", cur, prev_fields);
                req_len++;
                if (mem_req_ready) begin
                    if (exp_mem_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL mem_req_unexpected: got addr %0h required no request", mem_addr);
                    end else begin
                        check("mem_req_fields", cur, exp_mem_q.pop_front());
                    end
                    last_req_len = req_len;
                    req_len      = 0;
                    prev_pending = 1'b0;
                end else begin
                    prev_pending = 1'b1;
                    prev_fields  = cur;
                end
            end
        end
    end

    // driver tasks: called at posedge+1, return at posedge+1 after acceptance
    task automatic ifu_req(input logic [AW-1:0] addr);
        bit ok = 1'b0;
        ifu_req_valid = 1'b1;
        ifu_addr      = addr;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ifu_req_ready) begin ok = 1'b1; break; end
        end
        if (!ok) bound_fail("ifu_req_ready");
        @(posedge clk); #1;
        ifu_req_valid = 1'b0;
    endtask

    task automatic lsu_req(input logic [AW-1:0] addr, input logic wen,
                           input logic [DW-1:0] wdata, input logic [MW-1:0] wmask);
        bit ok = 1'b0;
        lsu_req_valid = 1'b1;
        lsu_addr      = addr;
        lsu_wen       = wen;
        lsu_wdata     = wdata;
        lsu_wmask     = wmask;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (lsu_req_ready) begin ok = 1'b1; break; end
        end
        if (!ok) bound_fail("lsu_req_ready");
        @(posedge clk); #1;
        lsu_req_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (exp_q.size() == 0 && dbg_state == 2'd0 && !mem_req_valid) begin ok = 1'b1; break; end
        end
        if (!ok) bound_fail(name);
    endtask

    // stimulus
    initial begin
        int rsp_cyc;
        bit seen;

        // reset: a pending IFU request must not be accepted while rst is high
        rst = 1'b1;
        ifu_req_valid = 1'b1;
        ifu_addr = 32'h8000_0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ifu_ready", ifu_req_ready, 1'b0);
        check("rst_lsu_ready", lsu_req_ready, 1'b0);
        check("rst_mem_req_valid", mem_req_valid, 1'b0);
        check("rst_rsp_valids", {ifu_rsp_valid, lsu_rsp_valid}, 2'b00);
        check("rst_owner_err", {owner, timeout_err}, 2'b00);
        check("rst_mem_fields", {mem_addr, mem_wen, mem_wdata, mem_wmask}, 69'h0);
        check("rst_state", dbg_state, 2'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // 1: IFU alone
        rsp_gap = 1;
        rsp_q.push_back(32'h0010_0093);
        exp_mem_q.push_back({32'h8000_0000, 1'b0, 32'h0, 4'h0});
        exp_q.push_back({1'b0, 32'h0010_0093});
        ifu_req(32'h8000_0000);
        wait_idle("t1_idle");

        // 2: conflict on the first cycle after reset, LSU wins
        rst = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        rsp_gap = 0;
        rsp_q.push_back(32'hAAAA_0001);
        rsp_q.push_back(32'hAAAA_0002);
        exp_mem_q.push_back({32'h8000_1000, 1'b0, 32'h0, 4'h0});
        exp_mem_q.push_back({32'h8000_0004, 1'b0, 32'h0, 4'h0});
        exp_q.push_back({1'b1, 32'hAAAA_0001});
        exp_q.push_back({1'b0, 32'hAAAA_0002});
        rst = 1'b0;
        ifu_req_valid = 1'b1;
        ifu_addr = 32'h8000_0004;
        lsu_req_valid = 1'b1;
        lsu_addr = 32'h8000_1000;
        lsu_wen = 1'b0;
        @(negedge clk);
        check("t2_lsu_ready", lsu_req_ready, 1'b1);
        check("t2_ifu_ready", ifu_req_ready, 1'b0);
        @(posedge clk); #1;
        lsu_req_valid = 1'b0;
        ifu_req(32'h8000_0004);
        wait_idle("t2_idle");

        // 3: both continuously valid, grants alternate L, I, L, I
        rsp_q.push_back(32'h3000_0001);
        rsp_q.push_back(32'h3000_0002);
        rsp_q.push_back(32'h3000_0003);
        rsp_q.push_back(32'h3000_0004);
        exp_mem_q.push_back({32'h8000_1100, 1'b0, 32'h0, 4'h0});
        exp_mem_q.push_back({32'h8000_0200, 1'b0, 32'h0, 4'h0});
        exp_mem_q.push_back({32'h8000_1104, 1'b1, 32'h5555_AAAA, 4'hF});
        exp_mem_q.push_back({32'h8000_0204, 1'b0, 32'h0, 4'h0});
        exp_q.push_back({1'b1, 32'h3000_0001});
        exp_q.push_back({1'b0, 32'h3000_0002});
        exp_q.push_back({1'b1, 32'h0});
        exp_q.push_back({1'b0, 32'h3000_0004});
        fork
            begin
                lsu_req(32'h8000_1100, 1'b0, 32'h0, 4'h0);
                lsu_req(32'h8000_1104, 1'b1, 32'h5555_AAAA, 4'hF);
            end
            begin
                ifu_req(32'h8000_0200);
                ifu_req(32'h8000_0204);
            end
        join
        wait_idle("t3_idle");

        // 4: LSU write with the memory stalling three cycles
        mem_stall = 3;
        rsp_q.push_back(32'hDEAD_BEEF);
        exp_mem_q.push_back({32'h8000_3000, 1'b1, 32'h1234_ABCD, 4'b0011});
        exp_q.push_back({1'b1, 32'h0});
        lsu_req(32'h8000_3000, 1'b1, 32'h1234_ABCD, 4'b0011);
        wait_idle("t4_idle");
        check("t4_req_cycles", last_req_len, 4);
        mem_stall = 0;

        // 5: memory never answers, watchdog aborts, next request still served
        check("t5_err_before", timeout_err, 1'b0);
        mem_silent = 1'b1;
        exp_mem_q.push_back({32'h8000_2000, 1'b0, 32'h0, 4'h0});
        exp_q.push_back({1'b1, 32'h0});
        lsu_req(32'h8000_2000, 1'b0, 32'h0, 4'h0);
        seen = 1'b0;
        rsp_cyc = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (lsu_rsp_valid) begin seen = 1'b1; rsp_cyc = cyc; break; end
        end
        if (!seen) bound_fail("t5_timeout_rsp");
        else check("t5_timeout_latency", rsp_cyc - hs_cyc, TO + 1);
        mem_silent = 1'b0;
        wait_idle("t5_idle");
        check("t5_err_set", timeout_err, 1'b1);
        rsp_q.push_back(32'h0000_0013);
        exp_mem_q.push_back({32'h8000_0300, 1'b0, 32'h0, 4'h0});
        exp_q.push_back({1'b0, 32'h0000_0013});
        ifu_req(32'h8000_0300);
        wait_idle("t5_after_idle");
        check("t5_err_sticky", timeout_err, 1'b1);

        // 6: reset in WAIT, late memory response must be ignored
        rsp_gap = 2;
        rsp_q.push_back(32'h0BAD_0BAD);
        exp_mem_q.push_back({32'h8000_0100, 1'b0, 32'h0, 4'h0});
        ifu_req(32'h8000_0100);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (dbg_state == 2'd2) begin seen = 1'b1; break; end
            @(posedge clk); #1;
        end
        if (!seen) bound_fail("t6_reach_wait");
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("t6_state_after_rst", dbg_state, 2'd0);
        check("t6_mem_req_valid", mem_req_valid, 1'b0);
        check("t6_mem_addr_cleared", mem_addr, 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        check("t6_late_rsp_ignored", {ifu_rsp_valid, lsu_rsp_valid}, 2'b00);
        check("t6_state_idle", dbg_state, 2'd0);
        repeat (4) @(posedge clk);
        #1;

        check("end_exp_q_empty", exp_q.size(), 0);
        check("end_exp_mem_q_empty", exp_mem_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
